// File: rtl/player_input_ctrl.sv
// player_input_ctrl
// Button front end for the player sprite path. Synchronizes and debounces
// the raw left/right/fire buttons, moves the player column at a fixed tick
// rate with clamping to the visible screen, and launches missiles by
// toggling a free slot bit in the missile toggle vector.
//
// Ports
//   i_clk            pixel clock
//   i_rst_n          asynchronous active-low reset
//   i_btn_left       raw button, high = pressed
//   i_btn_right      raw button, high = pressed
//   i_btn_fire       raw button, high = pressed
//   i_missle_busy    per-slot in-flight flags from the downstream stage
//   o_btn_col        registered player column
//   o_btn_missle_en  registered missile toggle vector, bits [7:3] are 0
//   o_fire_pulse     one-cycle strobe when a missile is launched
//
// Fire FSM
//   state   | meaning
//   IDLE    | waiting for debounced fire to rise
//   LAUNCH  | one cycle: pick lowest free slot, toggle it and strobe
//   RELEASE | waiting for debounced fire to fall (no auto-repeat)

module player_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 315000,
    parameter int MOVE_TICK       = 250000,
    parameter int STEP            = 2,
    parameter int COL_MIN         = 0,
    parameter int COL_MAX         = 624,
    parameter int COL_INIT        = 312
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    input  logic        i_btn_fire,
    input  logic [2:0]  i_missle_busy,
    output logic [11:0] o_btn_col,
    output logic [7:0]  o_btn_missle_en,
    output logic        o_fire_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(MOVE_TICK + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_TICK - 1);

    localparam logic [11:0] C_MIN      = 12'(COL_MIN);
    localparam logic [11:0] C_MAX      = 12'(COL_MAX);
    localparam logic [11:0] C_STEP     = 12'(STEP);
    localparam logic [11:0] C_INIT     = 12'(COL_INIT);
    localparam logic [11:0] C_LO_LIMIT = 12'(COL_MIN + STEP);
    localparam logic [11:0] C_HI_LIMIT = 12'(COL_MAX - STEP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RELEASE = 2'd2
    } fire_state_t;

    // Button index: 0 = left, 1 = right, 2 = fire
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [DW-1:0] r_deb_cnt [3];

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic          w_move_left;
    logic          w_move_right;
    logic [11:0]   r_col;

    fire_state_t   r_state;
    fire_state_t   w_state_nxt;
    logic [2:0]    w_toggle;
    logic          w_fire;
    logic [2:0]    r_missle_en;
    logic          r_fire_pulse;

    assign w_raw = {i_btn_fire, i_btn_right, i_btn_left};

    // Two-flop synchronizer followed by a per-button stability counter.
    // The counter only runs while the synchronized level disagrees with
    // the accepted level, so any glitch shorter than the window resets it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_tick       = (r_tick_cnt == TICK_LAST);
    assign w_move_left  = r_deb[0] & ~r_deb[1];
    assign w_move_right = r_deb[1] & ~r_deb[0];

    // Clamp is decided before the add/subtract so the 12-bit column can
    // never wrap below COL_MIN or overshoot COL_MAX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            r_col      <= C_INIT;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                if (w_move_left) begin
                    r_col <= (r_col < C_LO_LIMIT) ? C_MIN : r_col - C_STEP;
                end else if (w_move_right) begin
                    r_col <= (r_col > C_HI_LIMIT) ? C_MAX : r_col + C_STEP;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_toggle    = 3'b000;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_deb[2]) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = RELEASE;
                // Lowest free slot wins; with all slots busy the shot is dropped.
                if (!i_missle_busy[0]) begin
                    w_toggle = 3'b001;
                end else if (!i_missle_busy[1]) begin
                    w_toggle = 3'b010;
                end else if (!i_missle_busy[2]) begin
                    w_toggle = 3'b100;
                end
                w_fire = |w_toggle;
            end
            RELEASE: begin
                if (!r_deb[2]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_missle_en  <= '0;
            r_fire_pulse <= 1'b0;
        end else begin
            r_missle_en  <= r_missle_en ^ w_toggle;
            r_fire_pulse <= w_fire;
        end
    end

    assign o_btn_col       = r_col;
    assign o_btn_missle_en = {5'b00000, r_missle_en};
    assign o_fire_pulse    = r_fire_pulse;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Testbench for player_input_ctrl with short debounce/tick parameters.
// Three instances share the same stimulus and differ only in COL_INIT
// (312, 623, 1) so both clamp boundaries are reachable quickly.

module tb_player_input_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        left;
    logic        right;
    logic        fire;
    logic [2:0]  busy;
    logic [11:0] col0, col1, col2;
    logic [7:0]  en0, en1, en2;
    logic        fp0, fp1, fp2;

    int n_vec     = 0;
    int n_miss    = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4), .MOVE_TICK(8), .STEP(2),
        .COL_MIN(0), .COL_MAX(624), .COL_INIT(312)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_btn_left(left), .i_btn_right(right), .i_btn_fire(fire),
        .i_missle_busy(busy),
        .o_btn_col(col0), .o_btn_missle_en(en0), .o_fire_pulse(fp0)
    );

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4), .MOVE_TICK(8), .STEP(2),
        .COL_MIN(0), .COL_MAX(624), .COL_INIT(623)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_btn_left(left), .i_btn_right(right), .i_btn_fire(fire),
        .i_missle_busy(busy),
        .o_btn_col(col1), .o_btn_missle_en(en1), .o_fire_pulse(fp1)
    );

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4), .MOVE_TICK(8), .STEP(2),
        .COL_MIN(0), .COL_MAX(624), .COL_INIT(1)
    ) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_btn_left(left), .i_btn_right(right), .i_btn_fire(fire),
        .i_missle_busy(busy),
        .o_btn_col(col2), .o_btn_missle_en(en2), .o_fire_pulse(fp2)
    );

    // Pulses are sampled mid-cycle so each one-cycle strobe counts once.
    always @(negedge clk) begin
        if (fp0) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    // Hold fire for 10 edges (long enough to debounce), then release and settle.
    task automatic press_fire();
        fire = 1'b1;
        step(10);
        fire = 1'b0;
        step(12);
    endtask

    initial begin
        rst_n = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        fire  = 1'b0;
        busy  = 3'b000;

        // Reset values
        step(3);
        chk("rst_col0", 32'(col0), 32'd312);
        chk("rst_col1", 32'(col1), 32'd623);
        chk("rst_en", 32'(en0), 32'h00);
        chk("rst_pulse", 32'(fp0), 32'd0);
        rst_n = 1'b1;
        step(20);
        chk("post_rst_col", 32'(col0), 32'd312);
        chk("post_rst_en", 32'(en0), 32'h00);
        chk("post_rst_pulses", 32'(pulse_cnt), 32'd0);

        // 3-cycle glitch is shorter than the debounce window
        fire = 1'b1;
        step(3);
        fire = 1'b0;
        step(12);
        chk("glitch_pulses", 32'(pulse_cnt), 32'd0);
        chk("glitch_en", 32'(en0), 32'h00);

        // Clean press: toggle lands 2 sync + 4 debounce + 2 FSM edges after the rise
        fire = 1'b1;
        step(7);
        chk("press_en_early", 32'(en0), 32'h00);
        chk("press_pulse_early", 32'(fp0), 32'd0);
        step(1);
        chk("press_en", 32'(en0), 32'h01);
        chk("press_pulse", 32'(fp0), 32'd1);
        step(1);
        chk("press_pulse_width", 32'(fp0), 32'd0);
        step(1);
        fire = 1'b0;
        step(12);
        chk("press_pulses", 32'(pulse_cnt), 32'd1);

        // Slot 0 busy -> slot 1 toggles
        busy = 3'b001;
        press_fire();
        chk("slot1_en", 32'(en0), 32'h03);
        chk("slot1_pulses", 32'(pulse_cnt), 32'd2);

        // All busy -> dropped shot
        busy = 3'b111;
        press_fire();
        chk("full_en", 32'(en0), 32'h03);
        chk("full_pulses", 32'(pulse_cnt), 32'd2);

        // Long hold -> exactly one launch, slot 0 toggles back off
        busy = 3'b000;
        fire = 1'b1;
        step(100);
        chk("hold_pulses", 32'(pulse_cnt), 32'd3);
        fire = 1'b0;
        step(12);
        chk("hold_en", 32'(en0), 32'h02);

        // Slots 0 and 1 busy -> slot 2 toggles
        busy = 3'b011;
        press_fire();
        chk("slot2_en", 32'(en0), 32'h06);
        chk("slot2_pulses", 32'(pulse_cnt), 32'd4);

        // Reset while in LAUNCH with a toggle pending
        busy = 3'b000;
        fire = 1'b1;
        step(7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(en0), 32'h00);
        chk("mid_rst_pulse", 32'(fp0), 32'd0);
        step(2);
        chk("mid_rst_en_hold", 32'(en0), 32'h00);
        rst_n = 1'b1;
        step(7);
        chk("rerelease_en_early", 32'(en0), 32'h00);
        chk("rerelease_pulses_early", 32'(pulse_cnt), 32'd4);
        step(1);
        chk("rerelease_en", 32'(en0), 32'h01);
        chk("rerelease_pulse", 32'(fp0), 32'd1);
        fire = 1'b0;
        step(12);
        chk("rerelease_pulses", 32'(pulse_cnt), 32'd5);

        // Right held: 6 edges to debounce, then 160 edges = 20 ticks
        do_reset();
        chk("motion_rst_col0", 32'(col0), 32'd312);
        right = 1'b1;
        step(6);
        step(160);
        chk("right_col0", 32'(col0), 32'd352);
        chk("right_clamp_col1", 32'(col1), 32'd624);
        chk("right_col2", 32'(col2), 32'd41);
        right = 1'b0;

        // Left held: 20 ticks down, clamp at 0 with no wrap
        do_reset();
        left = 1'b1;
        step(6);
        step(160);
        chk("left_col0", 32'(col0), 32'd272);
        chk("left_col1", 32'(col1), 32'd583);
        chk("left_clamp_col2", 32'(col2), 32'd0);
        left = 1'b0;

        // Both held -> no motion
        do_reset();
        left  = 1'b1;
        right = 1'b1;
        step(86);
        chk("both_col0", 32'(col0), 32'd312);
        chk("both_col1", 32'(col1), 32'd623);
        chk("both_col2", 32'(col2), 32'd1);
        left  = 1'b0;
        right = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
